// File: rtl/led_chase_ctrl_pkg.sv
// Shared types for the chasing-LED sequencer.
// State encoding and slow-clock reset level.
package led_chase_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_UP,
    RUN_DN,
    HOLD
  } chase_state_t;

  // Delay generator comes out of reset high
  localparam logic SLW_RST = 1'b1;

endpackage

// File: rtl/led_chase_ctrl_if.sv
// Control and LED bundle for the chasing-LED sequencer.
// master drives the controls, slave is the sequencer.
interface led_chase_if #(
  parameter int N_LED = 8,
  parameter int LAP_W = 8,
  parameter int PW    = (N_LED > 1) ? $clog2(N_LED) : 1
);

  logic             slw_clk;
  logic             en;
  logic             dir;
  logic             bounce;
  logic             hold;
  logic [N_LED-1:0] led;
  logic [PW-1:0]    pos;
  logic             step;
  logic             end_evt;
  logic [LAP_W-1:0] lap_cnt;

  modport master (
    output slw_clk, en, dir, bounce, hold,
    input  led, pos, step, end_evt, lap_cnt
  );

  modport slave (
    input  slw_clk, en, dir, bounce, hold,
    output led, pos, step, end_evt, lap_cnt
  );

endinterface

// File: rtl/led_chase_ctrl_rise_edge_det.sv
// Rising-edge detector: one register plus AND.
// Reset level is chosen so a high input at release gives no pulse.
module rise_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/led_chase_ctrl.sv
// Chasing-LED sequencer: FSM, position counter,
// one-hot decoder and lap counter, all outputs registered.
module led_chase_ctrl
  import led_chase_ctrl_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int LAP_W = 8
) (
  input logic        clk,
  input logic        reset,
  led_chase_if.slave bus
);

  localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PW-1:0] TOP = PW'(N_LED - 1);
  localparam logic [PW-1:0] BOT = '0;
  localparam logic [PW-1:0] ONE = PW'(1);

  chase_state_t     state;
  chase_state_t     ret_st;
  chase_state_t     nxt_st;
  logic [PW-1:0]    pos;
  logic [PW-1:0]    nxt_pos;
  logic             nxt_end;
  logic [N_LED-1:0] led;
  logic             step;
  logic             end_evt;
  logic [LAP_W-1:0] lap;
  logic             rise;

  function automatic logic [N_LED-1:0] dec(
    input logic [PW-1:0] p
  );
    return N_LED'(1) << p;
  endfunction

  rise_edge_det #(
    .RST_VAL (SLW_RST)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (bus.slw_clk),
    .pulse (rise)
  );

  // Wrap follows dir each step; bounce follows the run state
  always_comb begin
    nxt_pos = pos;
    nxt_st  = state;
    nxt_end = 1'b0;
    if (!bus.bounce) begin
      if (!bus.dir) begin
        nxt_st = RUN_UP;
        if (pos == TOP) begin
          nxt_pos = BOT;
          nxt_end = 1'b1;
        end else begin
          nxt_pos = pos + ONE;
        end
      end else begin
        nxt_st = RUN_DN;
        if (pos == BOT) begin
          nxt_pos = TOP;
          nxt_end = 1'b1;
        end else begin
          nxt_pos = pos - ONE;
        end
      end
    end else if (state == RUN_DN) begin
      if (pos == BOT) begin
        nxt_pos = ONE;
        nxt_st  = RUN_UP;
        nxt_end = 1'b1;
      end else begin
        nxt_pos = pos - ONE;
      end
    end else begin
      if (pos == TOP) begin
        nxt_pos = TOP - ONE;
        nxt_st  = RUN_DN;
        nxt_end = 1'b1;
      end else begin
        nxt_pos = pos + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ret_st  <= IDLE;
      pos     <= '0;
      led     <= '0;
      step    <= 1'b0;
      end_evt <= 1'b0;
      lap     <= '0;
    end else begin
      step    <= 1'b0;
      end_evt <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        pos   <= '0;
        led   <= '0;
        lap   <= '0;
      end else begin
        case (state)
          IDLE: begin
            lap <= '0;
            if (bus.dir) begin
              state <= RUN_DN;
              pos   <= TOP;
              led   <= dec(TOP);
            end else begin
              state <= RUN_UP;
              pos   <= BOT;
              led   <= dec(BOT);
            end
          end
          RUN_UP, RUN_DN: begin
            if (bus.hold) begin
              state  <= HOLD;
              ret_st <= state;
            end else if (rise) begin
              state   <= nxt_st;
              pos     <= nxt_pos;
              led     <= dec(nxt_pos);
              step    <= 1'b1;
              end_evt <= nxt_end;
              if (nxt_end) lap <= lap + 1'b1;
            end
          end
          HOLD: begin
            if (!bus.hold) state <= ret_st;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.led     = led;
  assign bus.pos     = pos;
  assign bus.step    = step;
  assign bus.end_evt = end_evt;
  assign bus.lap_cnt = lap;

endmodule

// File: tb/tb_led_chase_ctrl.sv
// Directed bench for led_chase_ctrl with N_LED=8:
// table vectors for wrap/bounce sweeps, hand sequences for hold/idle/dir.
module tb_led_chase_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  led_chase_if #(.N_LED(8), .LAP_W(8)) bus ();

  led_chase_ctrl #(
    .N_LED (8),
    .LAP_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       dir;
    logic       bounce;
    logic [7:0] led;
    logic [2:0] pos;
    logic       end_evt;
    logic [7:0] lap;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slow_edge();
    bus.slw_clk = 1'b1;
    tick();
  endtask

  task automatic slow_fall();
    bus.slw_clk = 1'b0;
    tick();
  endtask

  task automatic apply(input int i);
    bus.dir    = tbl[i].dir;
    bus.bounce = tbl[i].bounce;
    slow_edge();
    chk($sformatf("v%0d pos", i), 32'(bus.pos), 32'(tbl[i].pos));
    chk($sformatf("v%0d led", i), 32'(bus.led), 32'(tbl[i].led));
    chk($sformatf("v%0d step", i), 32'(bus.step), 32'd1);
    chk($sformatf("v%0d end", i), 32'(bus.end_evt),
        32'(tbl[i].end_evt));
    chk($sformatf("v%0d lap", i), 32'(bus.lap_cnt), 32'(tbl[i].lap));
    slow_fall();
    chk($sformatf("v%0d step_off", i), 32'(bus.step), 32'd0);
  endtask

  task automatic restart(input logic d, input logic b);
    bus.en     = 1'b0;
    bus.hold   = 1'b0;
    tick();
    bus.dir    = d;
    bus.bounce = b;
    bus.en     = 1'b1;
    tick();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // wrap sweep: 9 edges from pos 0
    tbl[0]  = '{1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'h04, 3'd2, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'h08, 3'd3, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h10, 3'd4, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 8'h20, 3'd5, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 8'h40, 3'd6, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 8'h80, 3'd7, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 8'd1};
    // bounce sweep: 15 edges from pos 0
    tbl[9]  = '{1'b0, 1'b1, 8'h02, 3'd1, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 8'h04, 3'd2, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b1, 8'h08, 3'd3, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 1'b1, 8'h10, 3'd4, 1'b0, 8'd0};
    tbl[13] = '{1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 1'b1, 8'h40, 3'd6, 1'b0, 8'd0};
    tbl[15] = '{1'b0, 1'b1, 8'h80, 3'd7, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 1'b1, 8'h40, 3'd6, 1'b1, 8'd1};
    tbl[17] = '{1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 8'd1};
    tbl[18] = '{1'b0, 1'b1, 8'h10, 3'd4, 1'b0, 8'd1};
    tbl[19] = '{1'b0, 1'b1, 8'h08, 3'd3, 1'b0, 8'd1};
    tbl[20] = '{1'b0, 1'b1, 8'h04, 3'd2, 1'b0, 8'd1};
    tbl[21] = '{1'b0, 1'b1, 8'h02, 3'd1, 1'b0, 8'd1};
    tbl[22] = '{1'b0, 1'b1, 8'h01, 3'd0, 1'b0, 8'd1};
    tbl[23] = '{1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 8'd2};

    reset       = 1'b1;
    bus.slw_clk = 1'b1;
    bus.en      = 1'b0;
    bus.dir     = 1'b0;
    bus.bounce  = 1'b0;
    bus.hold    = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle led", 32'(bus.led), 32'd0);
      chk("idle step", 32'(bus.step), 32'd0);
      chk("idle lap", 32'(bus.lap_cnt), 32'd0);
    end
    chk("idle pos", 32'(bus.pos), 32'd0);
    slow_fall();

    // wrap sweep
    restart(1'b0, 1'b0);
    chk("entry pos", 32'(bus.pos), 32'd0);
    chk("entry led", 32'(bus.led), 32'h01);
    chk("entry step", 32'(bus.step), 32'd0);
    for (int i = 0; i < 9; i++) apply(i);

    // bounce sweep
    restart(1'b0, 1'b1);
    chk("bounce lap clr", 32'(bus.lap_cnt), 32'd0);
    for (int i = 9; i < 24; i++) apply(i);

    // hold asserted with an edge, then held across 4 edges
    restart(1'b0, 1'b0);
    repeat (3) begin
      slow_edge();
      slow_fall();
    end
    chk("pre-hold pos", 32'(bus.pos), 32'd3);
    bus.hold = 1'b1;
    slow_edge();
    chk("hold+edge pos", 32'(bus.pos), 32'd3);
    chk("hold+edge step", 32'(bus.step), 32'd0);
    slow_fall();
    for (int k = 0; k < 4; k++) begin
      slow_edge();
      chk($sformatf("held pos %0d", k), 32'(bus.pos), 32'd3);
      chk($sformatf("held led %0d", k), 32'(bus.led), 32'h08);
      chk($sformatf("held step %0d", k), 32'(bus.step), 32'd0);
      slow_fall();
    end
    bus.hold = 1'b0;
    tick();
    chk("release pos", 32'(bus.pos), 32'd3);
    slow_edge();
    chk("resume pos", 32'(bus.pos), 32'd4);
    chk("resume led", 32'(bus.led), 32'h10);
    chk("resume step", 32'(bus.step), 32'd1);
    slow_fall();

    // wrap mode direction flip at pos 2
    restart(1'b0, 1'b0);
    repeat (2) begin
      slow_edge();
      slow_fall();
    end
    chk("flip start", 32'(bus.pos), 32'd2);
    bus.dir = 1'b1;
    slow_edge();
    chk("flip pos1", 32'(bus.pos), 32'd1);
    chk("flip end1", 32'(bus.end_evt), 32'd0);
    slow_fall();
    slow_edge();
    chk("flip pos0", 32'(bus.pos), 32'd0);
    slow_fall();
    slow_edge();
    chk("flip pos7", 32'(bus.pos), 32'd7);
    chk("flip led7", 32'(bus.led), 32'h80);
    chk("flip end7", 32'(bus.end_evt), 32'd1);
    chk("flip lap", 32'(bus.lap_cnt), 32'd1);
    slow_fall();
    chk("flip end off", 32'(bus.end_evt), 32'd0);
    repeat (2) begin
      slow_edge();
      slow_fall();
    end
    chk("pre-off pos", 32'(bus.pos), 32'd5);

    // en=0 beats hold and edge in the same cycle
    bus.en   = 1'b0;
    bus.hold = 1'b1;
    slow_edge();
    chk("off led", 32'(bus.led), 32'd0);
    chk("off pos", 32'(bus.pos), 32'd0);
    chk("off lap", 32'(bus.lap_cnt), 32'd0);
    chk("off step", 32'(bus.step), 32'd0);
    chk("off end", 32'(bus.end_evt), 32'd0);
    slow_fall();
    chk("off stays", 32'(bus.led), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
